// File: rtl/bus_defs.sv
// Shared bus definitions: widths, transfer direction and
// master interface FSM state encodings.
package bus_defs;

    localparam int BUS_ADDR_W = 30;
    localparam int BUS_DATA_W = 32;

    localparam logic READ  = 1'b0;
    localparam logic WRITE = 1'b1;

    typedef enum logic [1:0] {
        BUS_IF_IDLE   = 2'd0,
        BUS_IF_REQ    = 2'd1,
        BUS_IF_ACCESS = 2'd2
    } bus_if_state_e;

endpackage

// File: rtl/bus_master_if.sv
// Master-side bus interface: single client transfer through req/grnt/as/rdy.
// Optional ACCESS timeout with cpu_err under BUS_MASTER_IF_TIMEOUT_EN.
module bus_master_if
    import bus_defs::*;
#(
    parameter int ADDR_WIDTH = BUS_ADDR_W,
    parameter int DATA_WIDTH = BUS_DATA_W
`ifdef BUS_MASTER_IF_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic                  clk,
    input  logic                  rst_,
    input  logic                  cpu_as,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic                  cpu_wr,
    input  logic [DATA_WIDTH-1:0] cpu_wr_data,
    output logic [DATA_WIDTH-1:0] cpu_rd_data,
    output logic                  cpu_rdy,
    output logic                  cpu_busy,
    output logic                  bus_req,
    input  logic                  bus_grnt,
    output logic                  bus_as,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic                  bus_wr,
    output logic [DATA_WIDTH-1:0] bus_wr_data,
    input  logic                  bus_rdy,
    input  logic [DATA_WIDTH-1:0] bus_rd_data
`ifdef BUS_MASTER_IF_TIMEOUT_EN
    , output logic                cpu_err
`endif
);

    bus_if_state_e         state_q, state_d;
    logic                  req_d, as_d, wr_d, rdy_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] wdata_d, rdata_d;

`ifdef BUS_MASTER_IF_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       err_d;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);
`endif

    // Client stalls while a transfer is pending or being accepted.
    assign cpu_busy = (state_q != BUS_IF_IDLE) | (cpu_as & ~cpu_rdy);

    // Next-state and next register values for the transfer FSM.
    always_comb begin
        state_d = state_q;
        req_d   = bus_req;
        as_d    = bus_as;
        addr_d  = bus_addr;
        wr_d    = bus_wr;
        wdata_d = bus_wr_data;
        rdata_d = cpu_rd_data;
        rdy_d   = 1'b0;
`ifdef BUS_MASTER_IF_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = 1'b0;
`endif
        unique case (state_q)
            BUS_IF_IDLE: begin
                if (cpu_as) begin
                    addr_d  = cpu_addr;
                    wr_d    = cpu_wr;
                    wdata_d = cpu_wr_data;
                    req_d   = 1'b1;
                    state_d = BUS_IF_REQ;
                end
            end
            BUS_IF_REQ: begin
                if (bus_grnt) begin
                    as_d    = 1'b1;
                    state_d = BUS_IF_ACCESS;
`ifdef BUS_MASTER_IF_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            BUS_IF_ACCESS: begin
                if (bus_rdy) begin
                    if (bus_wr == READ)
                        rdata_d = bus_rd_data;
                    rdy_d   = 1'b1;
                    req_d   = 1'b0;
                    as_d    = 1'b0;
                    state_d = BUS_IF_IDLE;
                end
`ifdef BUS_MASTER_IF_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    rdata_d = '0;
                    rdy_d   = 1'b1;
                    err_d   = 1'b1;
                    req_d   = 1'b0;
                    as_d    = 1'b0;
                    state_d = BUS_IF_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            default: begin
                req_d   = 1'b0;
                as_d    = 1'b0;
                state_d = BUS_IF_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops any transfer in flight.
    always_ff @(posedge clk) begin
        if (rst_) begin
            state_q     <= BUS_IF_IDLE;
            bus_req     <= 1'b0;
            bus_as      <= 1'b0;
            bus_addr    <= '0;
            bus_wr      <= READ;
            bus_wr_data <= '0;
            cpu_rd_data <= '0;
            cpu_rdy     <= 1'b0;
`ifdef BUS_MASTER_IF_TIMEOUT_EN
            cnt_q       <= '0;
            cpu_err     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bus_req     <= req_d;
            bus_as      <= as_d;
            bus_addr    <= addr_d;
            bus_wr      <= wr_d;
            bus_wr_data <= wdata_d;
            cpu_rd_data <= rdata_d;
            cpu_rdy     <= rdy_d;
`ifdef BUS_MASTER_IF_TIMEOUT_EN
            cnt_q       <= cnt_d;
            cpu_err     <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_bus_master_if.sv
// Directed testbench for bus_master_if.
// Covers BUS_MASTER_IF_TIMEOUT_EN when that macro is defined.
module tb_bus_master_if;

    logic        clk = 1'b0;
    logic        rst_;
    logic        cpu_as;
    logic [29:0] cpu_addr;
    logic        cpu_wr;
    logic [31:0] cpu_wr_data;
    logic [31:0] cpu_rd_data;
    logic        cpu_rdy;
    logic        cpu_busy;
    logic        bus_req;
    logic        bus_grnt;
    logic        bus_as;
    logic [29:0] bus_addr;
    logic        bus_wr;
    logic [31:0] bus_wr_data;
    logic        bus_rdy;
    logic [31:0] bus_rd_data;
`ifdef BUS_MASTER_IF_TIMEOUT_EN
    logic        cpu_err;
`endif

    int tests = 0;
    int fails = 0;

    bus_master_if #(
        .ADDR_WIDTH(30),
        .DATA_WIDTH(32)
`ifdef BUS_MASTER_IF_TIMEOUT_EN
        , .TIMEOUT_CYCLES(4)
`endif
    ) dut (
        .clk(clk),
        .rst_(rst_),
        .cpu_as(cpu_as),
        .cpu_addr(cpu_addr),
        .cpu_wr(cpu_wr),
        .cpu_wr_data(cpu_wr_data),
        .cpu_rd_data(cpu_rd_data),
        .cpu_rdy(cpu_rdy),
        .cpu_busy(cpu_busy),
        .bus_req(bus_req),
        .bus_grnt(bus_grnt),
        .bus_as(bus_as),
        .bus_addr(bus_addr),
        .bus_wr(bus_wr),
        .bus_wr_data(bus_wr_data),
        .bus_rdy(bus_rdy),
        .bus_rd_data(bus_rd_data)
`ifdef BUS_MASTER_IF_TIMEOUT_EN
        , .cpu_err(cpu_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_        = 1'b1;
        cpu_as      = 1'b0;
        cpu_addr    = '0;
        cpu_wr      = 1'b0;
        cpu_wr_data = '0;
        bus_grnt    = 1'b0;
        bus_rdy     = 1'b0;
        bus_rd_data = '0;
        tick();
        tick();
        check("rst_req", 64'(bus_req), 64'd0);
        check("rst_as", 64'(bus_as), 64'd0);
        check("rst_rdy", 64'(cpu_rdy), 64'd0);
        check("rst_busy", 64'(cpu_busy), 64'd0);
        check("rst_wr", 64'(bus_wr), 64'd0);
        check("rst_rdata", 64'(cpu_rd_data), 64'd0);
        rst_ = 1'b0;
        tick();

        // Minimum-latency read.
        bus_grnt    = 1'b1;
        bus_rdy     = 1'b1;
        bus_rd_data = 32'h5;
        cpu_addr    = 30'h0800_0000;
        cpu_wr      = 1'b0;
        cpu_as      = 1'b1;
        #1;
        check("rd_busy0", 64'(cpu_busy), 64'd1);
        tick();
        check("rd_req1", 64'(bus_req), 64'd1);
        check("rd_as1", 64'(bus_as), 64'd0);
        check("rd_addr1", 64'(bus_addr), 64'h0800_0000);
        tick();
        check("rd_as2", 64'(bus_as), 64'd1);
        check("rd_rdy2", 64'(cpu_rdy), 64'd0);
        tick();
        check("rd_rdy3", 64'(cpu_rdy), 64'd1);
        check("rd_data3", 64'(cpu_rd_data), 64'h5);
        check("rd_as3", 64'(bus_as), 64'd0);
        check("rd_req3", 64'(bus_req), 64'd0);
        check("rd_busy3", 64'(cpu_busy), 64'd0);
        cpu_as = 1'b0;
        tick();
        check("rd_rdy4", 64'(cpu_rdy), 64'd0);
        check("rd_hold4", 64'(cpu_rd_data), 64'h5);

        // Write with grant delayed four cycles.
        bus_grnt    = 1'b0;
        bus_rd_data = 32'h77;
        cpu_addr    = 30'h0000_0123;
        cpu_wr      = 1'b1;
        cpu_wr_data = 32'hDEAD_BEEF;
        cpu_as      = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("wr_req_wait", 64'(bus_req), 64'd1);
            check("wr_as_wait", 64'(bus_as), 64'd0);
        end
        check("wr_wr", 64'(bus_wr), 64'd1);
        check("wr_wdata", 64'(bus_wr_data), 64'hDEAD_BEEF);
        bus_grnt = 1'b1;
        tick();
        check("wr_as", 64'(bus_as), 64'd1);
        tick();
        check("wr_rdy", 64'(cpu_rdy), 64'd1);
        check("wr_rdata", 64'(cpu_rd_data), 64'h5);
        cpu_as = 1'b0;
        cpu_wr = 1'b0;
        tick();

        // Slave stalls three cycles while the client address moves.
        bus_rdy     = 1'b0;
        bus_rd_data = 32'hCAFE;
        cpu_addr    = 30'h0000_0ABC;
        cpu_as      = 1'b1;
        tick();
        tick();
        check("st_as", 64'(bus_as), 64'd1);
        cpu_addr    = 30'h3FFF_FFFF;
        cpu_wr_data = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("st_addr", 64'(bus_addr), 64'h0ABC);
            check("st_rdy", 64'(cpu_rdy), 64'd0);
            check("st_busy", 64'(cpu_busy), 64'd1);
            check("st_as_hold", 64'(bus_as), 64'd1);
        end
        bus_rdy = 1'b1;
        tick();
        check("st_done", 64'(cpu_rdy), 64'd1);
        check("st_data", 64'(cpu_rd_data), 64'hCAFE);
        cpu_as = 1'b0;
        tick();

        // Back-to-back reads, slave 1 then slave 2.
        bus_rd_data = 32'h1;
        cpu_addr    = 30'h1000_0000;
        cpu_as      = 1'b1;
        tick();
        tick();
        tick();
        check("bb_rdy1", 64'(cpu_rdy), 64'd1);
        check("bb_data1", 64'(cpu_rd_data), 64'h1);
        check("bb_gap", 64'(bus_req), 64'd0);
        cpu_addr    = 30'h2000_0000;
        bus_rd_data = 32'h2;
        tick();
        check("bb_req2", 64'(bus_req), 64'd1);
        check("bb_addr2", 64'(bus_addr), 64'h2000_0000);
        check("bb_norp", 64'(cpu_rdy), 64'd0);
        tick();
        check("bb_mid", 64'(cpu_rdy), 64'd0);
        tick();
        check("bb_rdy2", 64'(cpu_rdy), 64'd1);
        check("bb_data2", 64'(cpu_rd_data), 64'h2);
        cpu_as = 1'b0;
        tick();

`ifdef BUS_MASTER_IF_TIMEOUT_EN
        // Slave never answers; abort after four ACCESS cycles.
        bus_rdy     = 1'b0;
        bus_rd_data = 32'h9;
        cpu_addr    = 30'h0000_0040;
        cpu_as      = 1'b1;
        tick();
        tick();
        check("to_as", 64'(bus_as), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("to_wait", 64'(cpu_rdy), 64'd0);
            check("to_noerr", 64'(cpu_err), 64'd0);
        end
        tick();
        check("to_rdy", 64'(cpu_rdy), 64'd1);
        check("to_err", 64'(cpu_err), 64'd1);
        check("to_data", 64'(cpu_rd_data), 64'd0);
        check("to_req", 64'(bus_req), 64'd0);
        check("to_as0", 64'(bus_as), 64'd0);
        cpu_as = 1'b0;
        tick();
        check("to_err1", 64'(cpu_err), 64'd0);
        bus_rdy = 1'b1;
`endif

        // Reset in the middle of ACCESS drops the transfer.
        bus_rdy     = 1'b0;
        bus_rd_data = 32'hBAD;
        cpu_addr    = 30'h0000_0055;
        cpu_as      = 1'b1;
        tick();
        tick();
        check("rs_as", 64'(bus_as), 64'd1);
        rst_   = 1'b1;
        cpu_as = 1'b0;
        tick();
        check("rs_req", 64'(bus_req), 64'd0);
        check("rs_as0", 64'(bus_as), 64'd0);
        check("rs_rdy", 64'(cpu_rdy), 64'd0);
        check("rs_busy", 64'(cpu_busy), 64'd0);
        check("rs_data", 64'(cpu_rd_data), 64'd0);
        rst_    = 1'b0;
        bus_rdy = 1'b1;
        tick();
        check("rs_norp", 64'(cpu_rdy), 64'd0);
        check("rs_idle", 64'(bus_req), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bus_master_if.md
Name: bus_master_if

Overview:
- Master-side bus interface unit; sits directly upstream of bus_top, one instance per master port (master_0..3).
- Accepts single load/store requests from a client (CPU IF/MEM stage, DMA) and runs the bus handshake: req/grnt arbitration, address strobe, wait for slave rdy.
- Returns read data to the client and stalls it while a transfer is in flight.

Parameters:
- ADDR_WIDTH, 30, word address width; matches bus_top.
- DATA_WIDTH, 32, data width; matches bus_top.
- TIMEOUT_CYCLES, 255, max ACCESS cycles before abort; used only with BUS_MASTER_IF_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst_  in  1  reset; synchronous, active-high.
- cpu_as  in  1  client request strobe; held until cpu_rdy.
- cpu_addr  in  ADDR_WIDTH  client word address.
- cpu_wr  in  1  READ/WRITE select.
- cpu_wr_data  in  DATA_WIDTH  client write data.
- cpu_rd_data  out  DATA_WIDTH  read data; valid with cpu_rdy and held afterwards.
- cpu_rdy  out  1  one-cycle completion pulse.
- cpu_busy  out  1  stall to client.
- bus_req  out  1  to master_N_req.
- bus_grnt  in  1  from master_N_grnt.
- bus_as  out  1  to master_N_as.
- bus_addr  out  ADDR_WIDTH  to master_N_addr.
- bus_wr  out  1  to master_N_wr.
- bus_wr_data  out  DATA_WIDTH  to master_N_wr_data.
- bus_rdy  in  1  from master_rdy.
- bus_rd_data  in  DATA_WIDTH  from master_data.

Behaviour:
- Reset values: all registered outputs 0, bus_wr=READ, state=IDLE. Reset overrides any operation in progress: the transfer is dropped, cpu_rdy is not pulsed, and bus_req falls on the next edge.
- FSM states: IDLE, REQ, ACCESS.
- IDLE: if cpu_as=1, latch addr/wr/wr_data into the bus_* registers, set bus_req<=1, go to REQ.
- REQ: when bus_grnt=1, set bus_as<=1 and go to ACCESS. Otherwise stay in REQ; there is no limit on grant wait.
- ACCESS: hold bus_as, addr, wr and wr_data stable. On bus_rdy=1:
  - capture bus_rd_data into cpu_rd_data (reads only; writes leave it unchanged);
  - set cpu_rdy<=1 for one cycle;
  - set bus_req<=0 and bus_as<=0;
  - go to IDLE.
- bus_rdy is ignored outside ACCESS. bus_grnt is ignored in ACCESS, because the arbiter holds the grant while req is high.
- cpu_busy = (state!=IDLE) | (state==IDLE & cpu_as & ~cpu_rdy). It deasserts in the cycle cpu_rdy=1.
- Back-to-back: a new cpu_as sampled in the cpu_rdy cycle (state IDLE) starts the next transfer immediately, giving a 1-cycle bus gap.
- Minimum latency with grnt and rdy already high: cpu_as at edge 0, REQ at edge 1, ACCESS at edge 2, cpu_rdy at edge 3 (3 cycles).
- Client inputs are not sampled outside IDLE; changes mid-transfer have no effect.

Optional Feature:
- Macro: BUS_MASTER_IF_TIMEOUT_EN.
- With the macro: an 8-bit counter clears on ACCESS entry and increments each ACCESS cycle with bus_rdy=0. When it reaches TIMEOUT_CYCLES:
  - go to IDLE;
  - drop bus_req and bus_as;
  - pulse cpu_rdy with cpu_rd_data=0;
  - pulse the extra output cpu_err for one cycle (reset value 0).
- If bus_rdy and timeout occur in the same cycle, bus_rdy wins: normal completion, no error.
- Without the macro: no counter, no cpu_err port, and ACCESS waits indefinitely.

Decomposition:
- Shared package bus_defs: ADDR_WIDTH/DATA_WIDTH defines, READ/WRITE encodings, FSM state encodings (BUS_IF_IDLE/REQ/ACCESS).
- No sub-module; FSM and datapath stay in one file. The timeout counter is inline under the macro.

Test Plan:
- Read, grnt tied 1, rdy tied 1, addr=30'h0800_0000, bus_rd_data=32'h5 -> bus_req rises at edge 1, bus_as high for 1 cycle, cpu_rdy at edge 3 with cpu_rd_data=5.
- Write, wr_data=32'hDEAD_BEEF, grnt delayed 4 cycles -> bus_req held for 4 cycles with bus_as=0; then bus_as=1, bus_wr=WRITE, bus_wr_data=DEADBEEF; cpu_rd_data unchanged.
- rdy low 3 cycles in ACCESS while cpu_addr changes -> bus_addr stays at the latched value; cpu_rdy follows the rdy edge; cpu_busy is 1 throughout.
- Back-to-back reads to slave 1, then slave 2 (data 1, 2) -> two cpu_rdy pulses 3 cycles apart, data 1 then 2, bus_req low for 1 cycle between them.
- rst_=1 asserted in ACCESS -> next edge: bus_req=0, bus_as=0, cpu_rdy=0, state IDLE; no spurious completion.
- BUS_MASTER_IF_TIMEOUT_EN, TIMEOUT_CYCLES=4, rdy stuck 0 -> cpu_err and cpu_rdy pulse after 4 ACCESS cycles, cpu_rd_data=0, bus_req released.
